// File: rtl/scard_pkg.sv
// Shared types and defaults for the smartcard receive path.
`timescale 1ns/1ps
package scard_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RECV = 2'd1,
        DONE = 2'd2
    } scard_state_e;

    localparam int unsigned SCARD_DEPTH = 32;
    localparam int unsigned SCARD_TMO_W = 16;

endpackage

// File: rtl/scard_rx_mem.sv
// DEPTH x 8 simple dual-port RAM: synchronous write, registered read.
`timescale 1ns/1ps
module scard_rx_mem #(
    parameter int unsigned DEPTH = 32,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          reset_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [7:0]    wdata_i,
    input  logic          re_i,
    input  logic [AW-1:0] raddr_i,
    output logic [7:0]    rdata_o
);

    logic [7:0] mem_q [DEPTH];
    logic [7:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Only the output register is reset; the array itself is left alone.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            rdata_q <= 8'h00;
        end else if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/scard_rx_buffer.sv
// Smartcard receive FIFO with optional idle-timeout packet detection
// (enable with SCARD_RXBUF_TIMEOUT_EN).
`timescale 1ns/1ps
module scard_rx_buffer
    import scard_pkg::*;
#(
    parameter int unsigned DEPTH = SCARD_DEPTH,
    parameter int unsigned TMO_W = SCARD_TMO_W
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic [7:0]               async_data,
    input  logic                     async_datardy,
    input  logic                     clear,
    input  logic                     rd_en,
    output logic [7:0]               rd_data,
    output logic                     rd_valid,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full,
    output logic                     overflow,
    input  logic [TMO_W-1:0]         timeout_cycles,
    output logic                     pkt_done
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          ovf_q, rd_valid_q;
    logic          pop, wr_acc;

    assign empty  = (count_q == '0);
    assign full   = (count_q == FULL_CNT);
    assign pop    = rd_en & ~empty;
    // A pop in the same cycle frees the slot, so a full buffer still accepts.
    assign wr_acc = async_datardy & (~full | pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_acc) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop)    rd_ptr_d = rd_ptr_q + AW'(1);
        if (wr_acc && !pop)      count_d = count_q + CW'(1);
        else if (pop && !wr_acc) count_d = count_q - CW'(1);
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            ovf_q      <= 1'b0;
            rd_valid_q <= 1'b0;
        end else if (clear) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            ovf_q      <= 1'b0;
            rd_valid_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            rd_valid_q <= pop;
            if (async_datardy && !wr_acc) ovf_q <= 1'b1;
        end
    end

    scard_rx_mem #(.DEPTH(DEPTH), .AW(AW)) u_mem (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .we_i    (wr_acc & ~clear),
        .waddr_i (wr_ptr_q),
        .wdata_i (async_data),
        .re_i    (pop & ~clear),
        .raddr_i (rd_ptr_q),
        .rdata_o (rd_data)
    );

    assign rd_valid = rd_valid_q;
    assign count    = count_q;
    assign overflow = ovf_q;

`ifdef SCARD_RXBUF_TIMEOUT_EN
    scard_state_e      state_q;
    logic [TMO_W-1:0]  timer_q;
    logic              pkt_done_q;

    // Dropped bytes still count as line activity.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q    <= IDLE;
            timer_q    <= '0;
            pkt_done_q <= 1'b0;
        end else if (clear) begin
            state_q    <= IDLE;
            timer_q    <= '0;
            pkt_done_q <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (async_datardy) begin
                        state_q <= RECV;
                        timer_q <= '0;
                    end
                end
                RECV: begin
                    if (async_datardy) begin
                        timer_q <= '0;
                    end else if (timeout_cycles != '0 &&
                                 timer_q == timeout_cycles - TMO_W'(1)) begin
                        state_q    <= DONE;
                        pkt_done_q <= 1'b1;
                    end else if (timer_q != '1) begin
                        timer_q <= timer_q + TMO_W'(1);
                    end
                end
                DONE: begin
                    if (async_datardy) begin
                        state_q    <= RECV;
                        timer_q    <= '0;
                        pkt_done_q <= 1'b0;
                    end
                end
                default: begin
                    state_q    <= IDLE;
                    timer_q    <= '0;
                    pkt_done_q <= 1'b0;
                end
            endcase
        end
    end

    assign pkt_done = pkt_done_q;
`else
    logic unused_tmo;
    assign unused_tmo = ^timeout_cycles;
    assign pkt_done   = 1'b0;
`endif

endmodule

// File: tb/tb_scard_rx_buffer.sv
// Scoreboard bench for scard_rx_buffer (DEPTH=32).
`timescale 1ns/1ps
module tb_scard_rx_buffer;

    localparam int DEPTH = 32;

    logic        clk_i = 1'b0;
    logic        reset_i = 1'b0;
    logic [7:0]  async_data = 8'h00;
    logic        async_datardy = 1'b0;
    logic        clear = 1'b0;
    logic        rd_en = 1'b0;
    logic [7:0]  rd_data;
    logic        rd_valid;
    logic [5:0]  count;
    logic        empty, full, overflow;
    logic [15:0] timeout_cycles = 16'd0;
    logic        pkt_done;

    int checks = 0;
    int errors = 0;
    int mcount = 0;
    logic [7:0] sb [$];
    logic [7:0] exp;
    logic [7:0] last_rd = 8'h00;

    scard_rx_buffer dut (
        .clk_i          (clk_i),
        .reset_i        (reset_i),
        .async_data     (async_data),
        .async_datardy  (async_datardy),
        .clear          (clear),
        .rd_en          (rd_en),
        .rd_data        (rd_data),
        .rd_valid       (rd_valid),
        .count          (count),
        .empty          (empty),
        .full           (full),
        .overflow       (overflow),
        .timeout_cycles (timeout_cycles),
        .pkt_done       (pkt_done)
    );

    always #5 clk_i = ~clk_i;

    task automatic cycle(input logic c, input logic dr,
                         input logic [7:0] d, input logic re);
        @(negedge clk_i);
        clear = c;
        async_datardy = dr;
        async_data = d;
        rd_en = re;
        @(posedge clk_i);
        #1;
        clear = 1'b0;
        async_datardy = 1'b0;
        rd_en = 1'b0;
    endtask

    task automatic write_byte(input logic [7:0] b);
        if (mcount < DEPTH) begin
            sb.push_back(b);
            mcount++;
        end
        cycle(1'b0, 1'b1, b, 1'b0);
    endtask

    task automatic do_clear();
        cycle(1'b1, 1'b0, 8'h00, 1'b0);
        sb.delete();
        mcount = 0;
    endtask

    task automatic test_reset();
        #1 reset_i = 1'b1;
        repeat (2) @(posedge clk_i);
        #1;
        checks++;
        if (count !== 6'd0 || empty !== 1'b1 || full !== 1'b0 ||
            overflow !== 1'b0 || rd_valid !== 1'b0 ||
            rd_data !== 8'h00 || pkt_done !== 1'b0) begin
            errors++;
            $display("FAIL reset: cnt=%0d emp=%b full=%b ovf=%b rv=%b rd=%h pd=%b",
                     count, empty, full, overflow, rd_valid, rd_data, pkt_done);
        end
        @(negedge clk_i);
        reset_i = 1'b0;
    endtask

    task automatic test_basic();
        write_byte(8'h3B);
        write_byte(8'h9F);
        write_byte(8'h95);
        checks++;
        if (count !== 6'd3) begin
            errors++;
            $display("FAIL basic_count: got %0d want 3", count);
        end
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 1'b0, 8'h00, 1'b1);
            exp = sb.pop_front();
            mcount--;
            last_rd = exp;
            checks++;
            if (rd_valid !== 1'b1 || rd_data !== exp || count !== 6'(mcount)) begin
                errors++;
                $display("FAIL basic_pop%0d: rv=%b rd=%h cnt=%0d want rd=%h cnt=%0d",
                         i, rd_valid, rd_data, count, exp, mcount);
            end
        end
        checks++;
        if (empty !== 1'b1) begin
            errors++;
            $display("FAIL basic_empty: got %b want 1", empty);
        end
    endtask

    task automatic test_empty_pop();
        cycle(1'b0, 1'b0, 8'h00, 1'b1);
        checks++;
        if (rd_valid !== 1'b0 || rd_data !== last_rd || count !== 6'd0) begin
            errors++;
            $display("FAIL empty_pop: rv=%b rd=%h cnt=%0d want rv=0 rd=%h",
                     rd_valid, rd_data, count, last_rd);
        end
    endtask

    task automatic test_overflow();
        for (int i = 0; i <= 32; i++) write_byte(8'(i));
        checks++;
        if (full !== 1'b1 || overflow !== 1'b1 || count !== 6'd32) begin
            errors++;
            $display("FAIL ovf_state: full=%b ovf=%b cnt=%0d want 1 1 32",
                     full, overflow, count);
        end
        for (int i = 0; i < 32; i++) begin
            cycle(1'b0, 1'b0, 8'h00, 1'b1);
            exp = sb.pop_front();
            mcount--;
            last_rd = exp;
            checks++;
            if (rd_valid !== 1'b1 || rd_data !== exp) begin
                errors++;
                $display("FAIL ovf_pop%0d: rv=%b rd=%h want %h", i, rv_s(), rd_data, exp);
            end
        end
        test_empty_pop();
        do_clear();
        checks++;
        if (overflow !== 1'b0 || empty !== 1'b1) begin
            errors++;
            $display("FAIL clear_ovf: ovf=%b emp=%b want 0 1", overflow, empty);
        end
    endtask

    function automatic logic rv_s();
        return rd_valid;
    endfunction

    task automatic test_wrap();
        for (int i = 0; i < 20; i++) write_byte(8'h40 + 8'(i));
        for (int i = 0; i < 20; i++) begin
            cycle(1'b0, 1'b0, 8'h00, 1'b1);
            exp = sb.pop_front();
            mcount--;
            checks++;
            if (rd_valid !== 1'b1 || rd_data !== exp) begin
                errors++;
                $display("FAIL wrap_popa%0d: rv=%b rd=%h want %h", i, rd_valid, rd_data, exp);
            end
        end
        for (int i = 0; i < 20; i++) write_byte(8'hC0 + 8'(i));
        checks++;
        if (count !== 6'd20) begin
            errors++;
            $display("FAIL wrap_count: got %0d want 20", count);
        end
        for (int i = 0; i < 20; i++) begin
            cycle(1'b0, 1'b0, 8'h00, 1'b1);
            exp = sb.pop_front();
            mcount--;
            last_rd = exp;
            checks++;
            if (rd_valid !== 1'b1 || rd_data !== exp) begin
                errors++;
                $display("FAIL wrap_popb%0d: rv=%b rd=%h want %h", i, rd_valid, rd_data, exp);
            end
        end
    endtask

    task automatic test_full_simul();
        do_clear();
        for (int i = 0; i < 32; i++) write_byte(8'h80 + 8'(i));
        cycle(1'b0, 1'b1, 8'hAA, 1'b1);
        exp = sb.pop_front();
        sb.push_back(8'hAA);
        checks++;
        if (rd_valid !== 1'b1 || rd_data !== exp || count !== 6'd32 ||
            overflow !== 1'b0 || full !== 1'b1) begin
            errors++;
            $display("FAIL full_simul: rv=%b rd=%h cnt=%0d ovf=%b want rd=%h cnt=32 ovf=0",
                     rd_valid, rd_data, count, overflow, exp);
        end
        for (int i = 0; i < 32; i++) begin
            cycle(1'b0, 1'b0, 8'h00, 1'b1);
            exp = sb.pop_front();
            mcount--;
            last_rd = exp;
            checks++;
            if (rd_valid !== 1'b1 || rd_data !== exp) begin
                errors++;
                $display("FAIL full_pop%0d: rv=%b rd=%h want %h", i, rd_valid, rd_data, exp);
            end
        end
    endtask

    task automatic test_clear();
        write_byte(8'h11);
        write_byte(8'h22);
        write_byte(8'h33);
        cycle(1'b1, 1'b1, 8'h44, 1'b1);
        sb.delete();
        mcount = 0;
        checks++;
        if (count !== 6'd0 || empty !== 1'b1 || rd_valid !== 1'b0 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL clear: cnt=%0d emp=%b rv=%b ovf=%b want 0 1 0 0",
                     count, empty, rd_valid, overflow);
        end
        last_rd = rd_data;
        write_byte(8'h55);
        cycle(1'b0, 1'b0, 8'h00, 1'b1);
        exp = sb.pop_front();
        mcount--;
        last_rd = exp;
        checks++;
        if (rd_valid !== 1'b1 || rd_data !== exp) begin
            errors++;
            $display("FAIL clear_after: rv=%b rd=%h want %h", rd_valid, rd_data, exp);
        end
    endtask

    task automatic test_timeout();
`ifdef SCARD_RXBUF_TIMEOUT_EN
        timeout_cycles = 16'd100;
        for (int k = 0; k < 4; k++) begin
            write_byte(8'h60 + 8'(k));
            repeat (50) cycle(1'b0, 1'b0, 8'h00, 1'b0);
            checks++;
            if (pkt_done !== 1'b0) begin
                errors++;
                $display("FAIL tmo_gap%0d: pkt_done=%b want 0", k, pkt_done);
            end
        end
        write_byte(8'h70);
        repeat (99) cycle(1'b0, 1'b0, 8'h00, 1'b0);
        checks++;
        if (pkt_done !== 1'b0) begin
            errors++;
            $display("FAIL tmo_99: pkt_done=%b want 0", pkt_done);
        end
        cycle(1'b0, 1'b0, 8'h00, 1'b0);
        checks++;
        if (pkt_done !== 1'b1) begin
            errors++;
            $display("FAIL tmo_100: pkt_done=%b want 1", pkt_done);
        end
        write_byte(8'h71);
        checks++;
        if (pkt_done !== 1'b0) begin
            errors++;
            $display("FAIL tmo_fall: pkt_done=%b want 0", pkt_done);
        end
        timeout_cycles = 16'd0;
        repeat (300) cycle(1'b0, 1'b0, 8'h00, 1'b0);
        checks++;
        if (pkt_done !== 1'b0) begin
            errors++;
            $display("FAIL tmo_disabled: pkt_done=%b want 0", pkt_done);
        end
`else
        timeout_cycles = 16'd3;
        write_byte(8'h60);
        repeat (10) cycle(1'b0, 1'b0, 8'h00, 1'b0);
        checks++;
        if (pkt_done !== 1'b0) begin
            errors++;
            $display("FAIL tmo_off: pkt_done=%b want 0", pkt_done);
        end
`endif
        do_clear();
    endtask

    task automatic test_async_reset();
        timeout_cycles = 16'd4;
        for (int i = 0; i < 5; i++) write_byte(8'hD0 + 8'(i));
        repeat (4) cycle(1'b0, 1'b0, 8'h00, 1'b0);
        checks++;
        if (count !== 6'd5) begin
            errors++;
            $display("FAIL arst_pre: cnt=%0d want 5", count);
        end
`ifdef SCARD_RXBUF_TIMEOUT_EN
        checks++;
        if (pkt_done !== 1'b1) begin
            errors++;
            $display("FAIL arst_pre_pd: pkt_done=%b want 1", pkt_done);
        end
`endif
        cycle(1'b0, 1'b0, 8'h00, 1'b1);
        #2 reset_i = 1'b1;
        #1;
        checks++;
        if (count !== 6'd0 || empty !== 1'b1 || full !== 1'b0 ||
            overflow !== 1'b0 || rd_valid !== 1'b0 ||
            rd_data !== 8'h00 || pkt_done !== 1'b0) begin
            errors++;
            $display("FAIL arst: cnt=%0d emp=%b full=%b ovf=%b rv=%b rd=%h pd=%b",
                     count, empty, full, overflow, rd_valid, rd_data, pkt_done);
        end
        #0.5 reset_i = 1'b0;
        sb.delete();
        mcount = 0;
        write_byte(8'hE7);
        cycle(1'b0, 1'b0, 8'h00, 1'b1);
        exp = sb.pop_front();
        mcount--;
        checks++;
        if (rd_valid !== 1'b1 || rd_data !== exp || empty !== 1'b1) begin
            errors++;
            $display("FAIL arst_after: rv=%b rd=%h emp=%b want rd=%h", rd_valid, rd_data, empty, exp);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_empty_pop();
        test_overflow();
        test_wrap();
        test_full_simul();
        test_clear();
        test_timeout();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
